// File: rtl/punc_fetch_pkg.sv
// Shared types for the PUNC instruction fetch unit: FSM state encoding,
// instruction queue entry layout and the default reset fetch address.
package punc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_plus1;
    } fetch_entry_t;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/fetch_queue.sv
// Shift-register instruction queue; entry 0 is always the registered head so
// the consumer sees a stable instruction that holds its value once drained.
module fetch_queue
    import punc_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  din,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t  entries [DEPTH];
    logic          pop_ok;
    logic          push_ok;
    logic [CW-1:0] wr_idx;

    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((int'(count) < DEPTH) || pop_ok);
    // A simultaneous pop frees the tail slot, so the write lands one lower.
    assign wr_idx  = count - CW'(pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH - 1; i++)
                if (pop_ok && (i + 1 < int'(count))) entries[i] <= entries[i+1];
            for (int i = 0; i < DEPTH; i++)
                if (push_ok && (i == int'(wr_idx))) entries[i] <= din;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    assign head = entries[0];

endmodule

// File: rtl/punc_fetch_unit.sv
// PUNC instruction fetch unit: single-outstanding memory reader feeding a small
// instruction queue. Define FETCH_PERF_CNT_EN to add push/flush perf counters.
module punc_fetch_unit
    import punc_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        ir_valid,
    output logic [15:0] ir,
    output logic [15:0] ir_pc,
    input  logic        ir_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] perf_fetch_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e  state, state_nxt;
    logic [15:0]   fetch_pc;
    logic [CW-1:0] q_count;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          push, pop, has_room;

    assign mem_req  = (state == ST_WAIT_ACK);
    assign mem_addr = fetch_pc;

    // Redirect wins over both ends of the queue: the returning word is stale.
    assign push       = (state == ST_WAIT_ACK) && mem_ack && !redirect;
    assign pop        = ir_valid && ir_ready;
    assign has_room   = (int'(q_count) < DEPTH) || pop;
    assign push_entry = '{instr: mem_rdata, pc_plus1: fetch_pc + 16'd1};

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .flush (redirect),
        .head  (head),
        .count (q_count)
    );

    assign ir_valid = (q_count != '0);
    assign ir       = head.instr;
    assign ir_pc    = head.pc_plus1;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (redirect)      state_nxt = ST_IDLE;
                else if (halt)     state_nxt = ST_HALTED;
                else if (has_room) state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (mem_ack)       state_nxt = (halt && !redirect) ? ST_HALTED : ST_IDLE;
                else if (redirect) state_nxt = ST_DRAIN;
            end
            // The abandoned request still owes one ack; swallow it here.
            ST_DRAIN:  if (mem_ack)  state_nxt = ST_IDLE;
            ST_HALTED: if (redirect) state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect)  fetch_pc <= redirect_pc;
            else if (push) fetch_pc <= fetch_pc + 16'd1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (push && perf_fetch_cnt != 16'hFFFF)     perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
            if (redirect && perf_flush_cnt != 16'hFFFF) perf_flush_cnt <= perf_flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_punc_fetch_unit.sv
// Directed bench for punc_fetch_unit (DEPTH=2, RESET_PC=0): streaming, full
// queue backpressure, redirect/drain, PC wrap, halt and mid-request reset.
module tb_punc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt = 1'b0;
    logic        ir_valid;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int nreq, nhd, seen;

    punc_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .ir_valid    (ir_valid),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_ready    (ir_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_ack = 1'b0; redirect = 1'b0; halt = 1'b0; ir_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset values
        step();
        chk("rst_mem_req",  16'(mem_req),  16'h0000);
        chk("rst_mem_addr", mem_addr,      16'h0000);
        chk("rst_ir_valid", 16'(ir_valid), 16'h0000);
        chk("rst_ir",       ir,            16'h0000);
        chk("rst_ir_pc",    ir_pc,         16'h0000);

        // Zero-wait acks, consumer always ready
        do_reset();
        ir_ready = 1'b1; nreq = 0; nhd = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (mem_req) begin
                chk("stream_addr", mem_addr, 16'(nreq));
                nreq++;
                mem_ack = 1'b1; mem_rdata = 16'hA000 | mem_addr;
            end else mem_ack = 1'b0;
            if (ir_valid) begin
                chk("stream_ir_pc", ir_pc, 16'(nhd + 1));
                chk("stream_ir",    ir,    16'hA000 | 16'(nhd));
                nhd++;
            end
        end
        chk("stream_nreq", 16'(nreq), 16'd3);
        chk("stream_nhd",  16'(nhd),  16'd3);

        // Full queue stops requests; a pop restarts them next cycle
        do_reset();
        nreq = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (mem_req) begin
                nreq++;
                mem_ack = 1'b1; mem_rdata = 16'hB000 | mem_addr;
            end else mem_ack = 1'b0;
        end
        chk("full_nreq",    16'(nreq),    16'd2);
        chk("full_mem_req", 16'(mem_req), 16'h0000);
        chk("full_ir_pc",   ir_pc,        16'h0001);
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        chk("refill_mem_req", 16'(mem_req), 16'h0001);
        chk("refill_addr",    mem_addr,     16'h0002);
        chk("refill_ir_pc",   ir_pc,        16'h0002);

        // Reset while a request is outstanding, acks during and after reset
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        #1;
        chk("midrst_mem_req",  16'(mem_req),  16'h0000);
        chk("midrst_ir_valid", 16'(ir_valid), 16'h0000);
        step();
        rst = 1'b0;
        step();
        chk("postrst_mem_req",  16'(mem_req),  16'h0001);
        chk("postrst_addr",     mem_addr,      16'h0000);
        chk("postrst_ir_valid", 16'(ir_valid), 16'h0000);
        mem_rdata = 16'hBEEF;
        step();
        mem_ack = 1'b0;
        chk("postrst_ir", ir, 16'hBEEF);

        // Redirect during WAIT_ACK, late ack dropped
        do_reset();
        ir_ready = 1'b1;
        step();
        chk("drain_req0", mem_addr, 16'h0000);
        redirect = 1'b1; redirect_pc = 16'h3000;
        step();
        redirect = 1'b0;
        chk("drain_mem_req_a", 16'(mem_req), 16'h0000);
        step();
        chk("drain_mem_req_b", 16'(mem_req), 16'h0000);
        step();
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        step();
        mem_ack = 1'b0;
        chk("drain_ir_valid", 16'(ir_valid), 16'h0000);
        step();
        chk("drain_new_req",   16'(mem_req),  16'h0001);
        chk("drain_new_addr",  mem_addr,      16'h3000);
        chk("drain_ir_valid2", 16'(ir_valid), 16'h0000);
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        step();
        mem_ack = 1'b0;
        chk("drain_ir",    ir,    16'h1234);
        chk("drain_ir_pc", ir_pc, 16'h3001);

        // PC wrap at FFFF, then redirect coincident with ack
        do_reset();
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        step();
        redirect = 1'b0;
        step();
        chk("wrap_addr", mem_addr, 16'hFFFF);
        mem_ack = 1'b1; mem_rdata = 16'h5555;
        step();
        mem_ack = 1'b0;
        chk("wrap_ir_pc", ir_pc, 16'h0000);
        chk("wrap_ir",    ir,    16'h5555);
        step();
        chk("wrap_next_addr", mem_addr, 16'h0000);
        mem_ack = 1'b1; mem_rdata = 16'h6666;
        redirect = 1'b1; redirect_pc = 16'h0100;
        step();
        mem_ack = 1'b0; redirect = 1'b0;
        chk("redir_ack_ir_valid", 16'(ir_valid), 16'h0000);
        chk("redir_ack_mem_req",  16'(mem_req),  16'h0000);
        step();
        chk("redir_ack_addr", mem_addr, 16'h0100);

        // Halt with outstanding request, resume by redirect
        do_reset();
        ir_ready = 1'b1;
        step();
        halt = 1'b1;
        step();
        chk("halt_req_held", 16'(mem_req), 16'h0001);
        chk("halt_addr_held", mem_addr,     16'h0000);
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        step();
        mem_ack = 1'b0;
        chk("halt_ir", ir, 16'h7777);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            seen += int'(mem_req);
        end
        chk("halted_no_req", 16'(seen), 16'd0);
        redirect = 1'b1; redirect_pc = 16'h0040; halt = 1'b0;
        step();
        redirect = 1'b0;
        step();
        chk("resume_req",  16'(mem_req), 16'h0001);
        chk("resume_addr", mem_addr,     16'h0040);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
